// File: rtl/skeleton_test.sv
// skeleton_test: single-cycle 32-bit bring-up core with a fixed program ROM,
// a 32x32 register file, a small data memory, and a test port that freezes
// the core and gives direct access to the register file.
module skeleton_test #(
   parameter int unsigned DMEM_WORDS = 16,
   parameter int unsigned ROM_WORDS  = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        test,
   input  logic        t_ctrl_writeEnable,
   input  logic [4:0]  t_ctrl_writeReg,
   input  logic [4:0]  t_ctrl_readRegA,
   input  logic [4:0]  t_ctrl_readRegB,
   input  logic [31:0] t_data_writeReg,
   output logic [31:0] t_data_readRegA,
   output logic [31:0] t_data_readRegB
);

   localparam int unsigned XLEN    = 32;
   localparam int unsigned NREGS   = 32;
   localparam int unsigned RIDX_W  = 5;
   localparam int unsigned IMM_W   = 17;
   localparam int unsigned PC_W    = $clog2(ROM_WORDS);
   localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

   // Opcodes
   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;

   // R-type ALU selects
   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;

   // Instruction word layout; the 17-bit immediate overlays rt..pad.
   typedef struct packed {
      logic [4:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] shamt;
      logic [4:0] aluop;
      logic [1:0] pad;
   } instr_t;

   // Encoders used to build the ROM image
   function automatic logic [XLEN-1:0] enc_r(input logic [4:0] rd,
                                             input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic [4:0] shamt,
                                             input logic [4:0] aluop);
      return {OP_R, rd, rs, rt, shamt, aluop, 2'b00};
   endfunction

   function automatic logic [XLEN-1:0] enc_i(input logic [4:0]       op,
                                             input logic [4:0]       rd,
                                             input logic [4:0]       rs,
                                             input logic [IMM_W-1:0] imm);
      return {op, rd, rs, imm};
   endfunction

   // Fixed bring-up program; every other address decodes to 0 (nop)
   function automatic logic [XLEN-1:0] rom_word(input logic [PC_W-1:0] addr);
      logic [XLEN-1:0] w;
      w = '0;
      case (int'(addr))
         0:  w = enc_i(OP_ADDI, 5'd1,  5'd0,  17'd5);
         1:  w = enc_i(OP_ADDI, 5'd2,  5'd0,  17'd3);
         2:  w = enc_r(5'd3, 5'd1, 5'd2, 5'd0, ALU_ADD);
         3:  w = enc_r(5'd4, 5'd1, 5'd2, 5'd0, ALU_SUB);
         4:  w = enc_r(5'd5, 5'd1, 5'd2, 5'd0, ALU_AND);
         5:  w = enc_r(5'd6, 5'd1, 5'd2, 5'd0, ALU_OR);
         6:  w = enc_r(5'd7, 5'd1, 5'd0, 5'd3, ALU_SLL);
         7:  w = enc_r(5'd8, 5'd1, 5'd0, 5'd1, ALU_SRA);
         8:  w = enc_i(OP_SW,   5'd3,  5'd0,  17'd0);
         9:  w = enc_i(OP_LW,   5'd9,  5'd0,  17'd0);
         10: w = enc_i(OP_ADDI, 5'd10, 5'd0,  17'd17);
         11: w = enc_i(OP_SW,   5'd10, 5'd0,  17'd1);
         12: w = enc_i(OP_LW,   5'd11, 5'd0,  17'd1);
         13: w = enc_i(OP_ADDI, 5'd12, 5'd0,  17'd20);
         14: w = enc_i(OP_ADDI, 5'd13, 5'd12, 17'd5);
         default: w = '0;
      endcase
      return w;
   endfunction

   // Architectural state
   logic [PC_W-1:0] pc;
   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] dmem [DMEM_WORDS];

   // Decode / datapath signals
   instr_t              instr;
   logic [XLEN-1:0]     imm;
   logic [XLEN-1:0]     rs_val;
   logic [XLEN-1:0]     rt_val;
   logic [XLEN-1:0]     rd_val;
   logic [XLEN-1:0]     ea;
   logic [DMEM_AW-1:0]  dmem_idx;
   logic                core_wen;
   logic [XLEN-1:0]     core_wdata;
   logic                mem_wen;
   logic                rf_wen;
   logic [RIDX_W-1:0]   rf_waddr;
   logic [XLEN-1:0]     rf_wdata;

   assign instr    = rom_word(pc);
   assign imm      = {{(XLEN-IMM_W){instr.rt[4]}}, instr.rt, instr.shamt, instr.aluop, instr.pad};
   assign rs_val   = regs[instr.rs];
   assign rt_val   = regs[instr.rt];
   assign rd_val   = regs[instr.rd];
   assign ea       = rs_val + imm;
   assign dmem_idx = DMEM_AW'(ea % XLEN'(DMEM_WORDS));

   // Execute: ALU result, register write request and store request
   always_comb begin
      core_wen   = 1'b0;
      core_wdata = '0;
      mem_wen    = 1'b0;
      case (instr.opcode)
         OP_R: begin
            core_wen = 1'b1;
            case (instr.aluop)
               ALU_ADD: core_wdata = rs_val + rt_val;
               ALU_SUB: core_wdata = rs_val - rt_val;
               ALU_AND: core_wdata = rs_val & rt_val;
               ALU_OR:  core_wdata = rs_val | rt_val;
               ALU_SLL: core_wdata = rs_val << instr.shamt;
               ALU_SRA: core_wdata = XLEN'($signed(rs_val) >>> instr.shamt);
               default: core_wen   = 1'b0;
            endcase
         end
         OP_ADDI: begin
            core_wen   = 1'b1;
            core_wdata = ea;
         end
         OP_SW: mem_wen = 1'b1;
         OP_LW: begin
            core_wen   = 1'b1;
            core_wdata = dmem[dmem_idx];
         end
         default: ;
      endcase
   end

   // Register-file write port: test port owns it while frozen
   always_comb begin
      rf_wen   = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (test) begin
         rf_wen   = t_ctrl_writeEnable;
         rf_waddr = t_ctrl_writeReg;
         rf_wdata = t_data_writeReg;
      end else begin
         rf_wen   = core_wen;
         rf_waddr = instr.rd;
         rf_wdata = core_wdata;
      end
   end

   // Program counter: advances while running, parks on the last (nop) word
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc <= '0;
      end else if (!test && (pc != PC_W'(ROM_WORDS - 1))) begin
         pc <= pc + 1'b1;
      end
   end

   // Register file; r0 is never written so it always reads zero
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (rf_wen && (rf_waddr != '0)) begin
         regs[rf_waddr] <= rf_wdata;
      end
   end

   // Data memory; stores are held off while the core is frozen
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            dmem[i] <= '0;
         end
      end else if (mem_wen && !test) begin
         dmem[dmem_idx] <= rd_val;
      end
   end

   // Test read ports are plain combinational reads
   assign t_data_readRegA = regs[t_ctrl_readRegA];
   assign t_data_readRegB = regs[t_ctrl_readRegB];

endmodule

// File: tb/tb_skeleton_test.sv
// Directed bench for skeleton_test: runs the ROM program and checks the
// register file through the test port under reset, freeze and write cases.
module tb_skeleton_test;

   logic        clock;
   logic        reset;
   logic        test;
   logic        t_ctrl_writeEnable;
   logic [4:0]  t_ctrl_writeReg;
   logic [4:0]  t_ctrl_readRegA;
   logic [4:0]  t_ctrl_readRegB;
   logic [31:0] t_data_writeReg;
   logic [31:0] t_data_readRegA;
   logic [31:0] t_data_readRegB;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   skeleton_test dut (
      .clock              (clock),
      .reset              (reset),
      .test               (test),
      .t_ctrl_writeEnable (t_ctrl_writeEnable),
      .t_ctrl_writeReg    (t_ctrl_writeReg),
      .t_ctrl_readRegA    (t_ctrl_readRegA),
      .t_ctrl_readRegB    (t_ctrl_readRegB),
      .t_data_writeReg    (t_data_writeReg),
      .t_data_readRegA    (t_data_readRegA),
      .t_data_readRegB    (t_data_readRegB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Final register values after the program, computed by hand
   function automatic logic [31:0] final_val(input int i);
      case (i)
         1:  return 32'd5;
         2:  return 32'd3;
         3:  return 32'd8;
         4:  return 32'd2;
         5:  return 32'd1;
         6:  return 32'd7;
         7:  return 32'd40;
         8:  return 32'd2;
         9:  return 32'd8;
         10: return 32'd17;
         11: return 32'd17;
         12: return 32'd20;
         13: return 32'd25;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic read_a(input string tag, input int idx, input logic [31:0] exp);
      t_ctrl_readRegA = 5'(idx);
      #1;
      check(tag, t_data_readRegA, exp);
   endtask

   task automatic check_all(input string prefix);
      for (int i = 0; i < 14; i++) begin
         read_a($sformatf("%s_r%0d", prefix, i), i, final_val(i));
      end
   endtask

   initial begin
      reset              = 1'b0;
      test               = 1'b0;
      t_ctrl_writeEnable = 1'b0;
      t_ctrl_writeReg    = '0;
      t_ctrl_readRegA    = 5'd5;
      t_ctrl_readRegB    = 5'd31;
      t_data_writeReg    = '0;

      // Reads during reset return zero
      @(negedge clock);
      #1;
      check("rst_a", t_data_readRegA, 32'd0);
      check("rst_b", t_data_readRegB, 32'd0);

      // Full program run
      @(negedge clock);
      reset = 1'b1;
      run(20);
      test = 1'b1;
      check_all("run");

      // Two different indices read in the same cycle
      t_ctrl_readRegA = 5'd7;
      t_ctrl_readRegB = 5'd8;
      #1;
      check("dual_a_r7", t_data_readRegA, 32'd40);
      check("dual_b_r8", t_data_readRegB, 32'd2);

      // Test write ignored while test=0; reads still live
      test               = 1'b0;
      t_ctrl_writeEnable = 1'b1;
      t_ctrl_writeReg    = 5'd1;
      t_data_writeReg    = 32'd99;
      run(2);
      t_ctrl_writeEnable = 1'b0;
      read_a("nowrite_r1", 1, 32'd5);

      // Test-port write: old value in the same cycle, new value after the edge
      test               = 1'b1;
      t_ctrl_writeEnable = 1'b1;
      t_ctrl_writeReg    = 5'd20;
      t_data_writeReg    = 32'hDEAD_BEEF;
      t_ctrl_readRegB    = 5'd20;
      #1;
      check("tw_same_cycle", t_data_readRegB, 32'd0);
      @(negedge clock);
      t_ctrl_writeEnable = 1'b0;
      #1;
      check("tw_r20", t_data_readRegB, 32'hDEAD_BEEF);

      // Test write to r0 is discarded
      t_ctrl_writeEnable = 1'b1;
      t_ctrl_writeReg    = 5'd0;
      t_data_writeReg    = 32'h0000_1234;
      @(negedge clock);
      t_ctrl_writeEnable = 1'b0;
      read_a("tw_r0", 0, 32'd0);

      // Asynchronous reset clears state immediately
      test            = 1'b0;
      reset           = 1'b0;
      t_ctrl_readRegA = 5'd13;
      t_ctrl_readRegB = 5'd20;
      #1;
      check("areset_a_r13", t_data_readRegA, 32'd0);
      check("areset_b_r20", t_data_readRegB, 32'd0);

      // Reset pulse mid-program, then a clean rerun
      @(negedge clock);
      reset = 1'b1;
      run(3);
      read_a("mid_pre_r1", 1, 32'd5);
      reset = 1'b0;
      read_a("mid_rst_r1", 1, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      run(20);
      test = 1'b1;
      check_all("rerun");

      // Freeze after five instructions
      test  = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      run(5);
      test = 1'b1;
      run(10);
      for (int i = 1; i < 14; i++) begin
         read_a($sformatf("frz_r%0d", i), i, (i <= 5) ? final_val(i) : 32'd0);
      end

      // Resume from the held PC
      test = 1'b0;
      run(20);
      test = 1'b1;
      check_all("resume");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
